// File: rtl/npu_ew_engine.sv
// Elementwise engine: streams SIZE elements of A (and B or the scalar M0VAL) through ADD/MUL/RQT into C.
// Latency: first C write 3 cycles after START, then one element per cycle; FINISH = START + SIZE + 3 (START + 1 if SIZE == 0).
// Backpressure: none; memories accept a read/write every cycle. START is ignored unless IDLE; SOFT_RESET aborts.
//
// Ports: CLK/RESET_X (async active-low) / SOFT_RESET (sync abort); START + latched configuration
// (OP, B_SCALAR, INV_A, INV_B, M0VAL, A_POS, B_POS, C_POS, SIZE, GAIN, QSHIFT); A/B read ports with
// 1-cycle read latency; C write port; BUSY, FINISH, RMAX/RMIN status.
// Optional macro NPU_EW_RELU_EN adds a RELU input that clamps negative results to 0.

module npu_ew_engine #(
   parameter int DW = 8,
   parameter int AW = 10,
   parameter int GW = 32,
   parameter int SW = 5
) (
   input  logic          CLK,
   input  logic          RESET_X,
   input  logic          SOFT_RESET,
   input  logic          START,
   input  logic [1:0]    OP,
   input  logic          B_SCALAR,
   input  logic          INV_A,
   input  logic          INV_B,
   input  logic [DW-1:0] M0VAL,
   input  logic [AW-1:0] A_POS,
   input  logic [AW-1:0] B_POS,
   input  logic [AW-1:0] C_POS,
   input  logic [AW-1:0] SIZE,
   input  logic [GW-1:0] GAIN,
   input  logic [SW-1:0] QSHIFT,
`ifdef NPU_EW_RELU_EN
   input  logic          RELU,
`endif
   output logic          A_RD,
   output logic [AW-1:0] A_RADR,
   input  logic [DW-1:0] A_RDATA,
   output logic          B_RD,
   output logic [AW-1:0] B_RADR,
   input  logic [DW-1:0] B_RDATA,
   output logic          C_WR,
   output logic [AW-1:0] C_WADR,
   output logic [DW-1:0] C_WDATA,
   output logic          BUSY,
   output logic          FINISH,
   output logic [DW-1:0] RMAX,
   output logic [DW-1:0] RMIN
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

   localparam logic [1:0] OP_MUL = 2'd1;
   localparam logic [1:0] OP_RQT = 2'd2;

   // Wide enough for A'*B'*GAIN plus the rounding constant without overflow.
   localparam int PW = 2*DW + GW + 2;
   localparam logic signed [PW-1:0] PW_ONE  = {{(PW-1){1'b0}}, 1'b1};
   localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

   // Negation that maps the most negative value onto the most positive one.
   function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] x);
      logic [DW-1:0] r;
      if (x == {1'b1, {(DW-1){1'b0}}}) r = {1'b0, {(DW-1){1'b1}}};
      else                             r = -x;
      return r;
   endfunction

   state_t state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   // Run configuration, frozen at START acceptance.
   logic [1:0]    op_q, op_d;
   logic          bsc_q, bsc_d;
   logic          inv_a_q, inv_a_d;
   logic          inv_b_q, inv_b_d;
   logic [DW-1:0] m0_q, m0_d;
   logic [AW-1:0] a_pos_q, a_pos_d;
   logic [AW-1:0] b_pos_q, b_pos_d;
   logic [AW-1:0] c_pos_q, c_pos_d;
   logic [AW-1:0] size_q, size_d;
   logic [GW-1:0] gain_q, gain_d;
   logic [SW-1:0] qsh_q, qsh_d;
`ifdef NPU_EW_RELU_EN
   logic          relu_q, relu_d;
`endif

   // Stage 1: read issued last cycle, data arrives this cycle.
   logic          s1_vld_q, s1_vld_d;
   logic [AW-1:0] s1_idx_q, s1_idx_d;
   // Stage 2: conditioned operands; result is computed and written this cycle.
   logic                 s2_vld_q, s2_vld_d;
   logic signed [DW-1:0] s2_a_q, s2_a_d;
   logic signed [DW-1:0] s2_b_q, s2_b_d;
   logic [AW-1:0]        s2_adr_q, s2_adr_d;

   logic signed [DW-1:0] rmax_q, rmax_d;
   logic signed [DW-1:0] rmin_q, rmin_d;
   logic                 first_q, first_d;

   logic [DW-1:0]        a_opnd, b_opnd, b_sel;
   logic signed [PW-1:0] a_ext, b_ext, g_ext, prod, rnd, full;
   logic signed [DW-1:0] res;

   // Operand conditioning for the element whose read data is returning now.
   always_comb begin
      b_sel  = bsc_q ? m0_q : B_RDATA;
      a_opnd = inv_a_q ? neg_sat(A_RDATA) : A_RDATA;
      b_opnd = inv_b_q ? neg_sat(b_sel) : b_sel;
   end

   // Full-precision compute and saturation for the element being written now.
   always_comb begin
      a_ext = {{(PW-DW){s2_a_q[DW-1]}}, s2_a_q};
      b_ext = {{(PW-DW){s2_b_q[DW-1]}}, s2_b_q};
      g_ext = {{(PW-GW){gain_q[GW-1]}}, gain_q};
      rnd   = '0;
      if (qsh_q != '0) rnd = PW_ONE << (qsh_q - SW'(1));
      case (op_q)
         OP_MUL:  prod = a_ext * b_ext * g_ext;
         OP_RQT:  prod = a_ext * g_ext;
         default: prod = a_ext + b_ext;
      endcase
      // Only the gain-scaled ops are rounded and shifted; ADD is used as-is.
      if (op_q == OP_MUL || op_q == OP_RQT) full = (prod + rnd) >>> qsh_q;
      else                                  full = prod;
      if (full > SAT_MAX)      res = SAT_MAX[DW-1:0];
      else if (full < SAT_MIN) res = SAT_MIN[DW-1:0];
      else                     res = full[DW-1:0];
`ifdef NPU_EW_RELU_EN
      if (relu_q && res[DW-1]) res = '0;
`endif
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      bsc_d    = bsc_q;
      inv_a_d  = inv_a_q;
      inv_b_d  = inv_b_q;
      m0_d     = m0_q;
      a_pos_d  = a_pos_q;
      b_pos_d  = b_pos_q;
      c_pos_d  = c_pos_q;
      size_d   = size_q;
      gain_d   = gain_q;
      qsh_d    = qsh_q;
`ifdef NPU_EW_RELU_EN
      relu_d   = relu_q;
`endif
      s1_vld_d = 1'b0;
      s1_idx_d = s1_idx_q;
      s2_vld_d = s1_vld_q;
      s2_a_d   = s2_a_q;
      s2_b_d   = s2_b_q;
      s2_adr_d = s2_adr_q;
      rmax_d   = rmax_q;
      rmin_d   = rmin_q;
      first_d  = first_q;

      if (s1_vld_q) begin
         s2_a_d   = a_opnd;
         s2_b_d   = b_opnd;
         s2_adr_d = c_pos_q + s1_idx_q;
      end

      if (s2_vld_q) begin
         first_d = 1'b0;
         if (first_q || res > rmax_q) rmax_d = res;
         if (first_q || res < rmin_q) rmin_d = res;
      end

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               op_d    = OP;
               bsc_d   = B_SCALAR;
               inv_a_d = INV_A;
               inv_b_d = INV_B;
               m0_d    = M0VAL;
               a_pos_d = A_POS;
               b_pos_d = B_POS;
               c_pos_d = C_POS;
               size_d  = SIZE;
               gain_d  = GAIN;
               qsh_d   = QSHIFT;
`ifdef NPU_EW_RELU_EN
               relu_d  = RELU;
`endif
               cnt_d   = '0;
               rmax_d  = '0;
               rmin_d  = '0;
               first_d = 1'b1;
               state_d = (SIZE == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            s1_vld_d = 1'b1;
            s1_idx_d = cnt_q;
            if (cnt_q == size_q - AW'(1)) state_d = ST_DRAIN;
            else                          cnt_d   = cnt_q + AW'(1);
         end
         // The last write happens in the cycle where stage 1 has emptied.
         ST_DRAIN: if (!s1_vld_q) state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase

      if (SOFT_RESET) begin
         state_d  = ST_IDLE;
         s1_vld_d = 1'b0;
         s2_vld_d = 1'b0;
         rmax_d   = '0;
         rmin_d   = '0;
         first_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_X) begin
      if (!RESET_X) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         bsc_q    <= 1'b0;
         inv_a_q  <= 1'b0;
         inv_b_q  <= 1'b0;
         m0_q     <= '0;
         a_pos_q  <= '0;
         b_pos_q  <= '0;
         c_pos_q  <= '0;
         size_q   <= '0;
         gain_q   <= '0;
         qsh_q    <= '0;
`ifdef NPU_EW_RELU_EN
         relu_q   <= 1'b0;
`endif
         s1_vld_q <= 1'b0;
         s1_idx_q <= '0;
         s2_vld_q <= 1'b0;
         s2_a_q   <= '0;
         s2_b_q   <= '0;
         s2_adr_q <= '0;
         rmax_q   <= '0;
         rmin_q   <= '0;
         first_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         bsc_q    <= bsc_d;
         inv_a_q  <= inv_a_d;
         inv_b_q  <= inv_b_d;
         m0_q     <= m0_d;
         a_pos_q  <= a_pos_d;
         b_pos_q  <= b_pos_d;
         c_pos_q  <= c_pos_d;
         size_q   <= size_d;
         gain_q   <= gain_d;
         qsh_q    <= qsh_d;
`ifdef NPU_EW_RELU_EN
         relu_q   <= relu_d;
`endif
         s1_vld_q <= s1_vld_d;
         s1_idx_q <= s1_idx_d;
         s2_vld_q <= s2_vld_d;
         s2_a_q   <= s2_a_d;
         s2_b_q   <= s2_b_d;
         s2_adr_q <= s2_adr_d;
         rmax_q   <= rmax_d;
         rmin_q   <= rmin_d;
         first_q  <= first_d;
      end
   end

   always_comb begin
      A_RD    = (state_q == ST_ISSUE);
      A_RADR  = A_RD ? a_pos_q + cnt_q : '0;
      // RQT ignores B and a scalar B never touches memory.
      B_RD    = A_RD && !bsc_q && (op_q != OP_RQT);
      B_RADR  = B_RD ? b_pos_q + cnt_q : '0;
      C_WR    = s2_vld_q;
      C_WADR  = s2_vld_q ? s2_adr_q : '0;
      C_WDATA = s2_vld_q ? res : '0;
      BUSY    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
      FINISH  = (state_q == ST_DONE);
      RMAX    = rmax_q;
      RMIN    = rmin_q;
   end

endmodule

// File: tb/tb_npu_ew_engine.sv
// Testbench for npu_ew_engine: directed cases plus randomized runs against an arithmetic reference model.
// Memory models answer reads one cycle after issue; all outputs are sampled on the falling edge.
// Summary line reports comparison and error counts.

module tb_npu_ew_engine;
   localparam int DW = 8;
   localparam int AW = 10;
   localparam int GW = 32;
   localparam int SW = 5;
   localparam int DEPTH = 1 << AW;
   localparam int VMAX = (1 << (DW-1)) - 1;
   localparam int VMIN = -(1 << (DW-1));

   logic          CLK, RESET_X, SOFT_RESET, START;
   logic [1:0]    OP;
   logic          B_SCALAR, INV_A, INV_B;
   logic [DW-1:0] M0VAL;
   logic [AW-1:0] A_POS, B_POS, C_POS, SIZE;
   logic [GW-1:0] GAIN;
   logic [SW-1:0] QSHIFT;
`ifdef NPU_EW_RELU_EN
   logic          RELU;
`endif
   logic          A_RD, B_RD, C_WR;
   logic [AW-1:0] A_RADR, B_RADR, C_WADR;
   logic [DW-1:0] A_RDATA, B_RDATA, C_WDATA;
   logic          BUSY, FINISH;
   logic [DW-1:0] RMAX, RMIN;

   npu_ew_engine #(.DW(DW), .AW(AW), .GW(GW), .SW(SW)) dut (
      .CLK(CLK), .RESET_X(RESET_X), .SOFT_RESET(SOFT_RESET), .START(START),
      .OP(OP), .B_SCALAR(B_SCALAR), .INV_A(INV_A), .INV_B(INV_B), .M0VAL(M0VAL),
      .A_POS(A_POS), .B_POS(B_POS), .C_POS(C_POS), .SIZE(SIZE), .GAIN(GAIN), .QSHIFT(QSHIFT),
`ifdef NPU_EW_RELU_EN
      .RELU(RELU),
`endif
      .A_RD(A_RD), .A_RADR(A_RADR), .A_RDATA(A_RDATA),
      .B_RD(B_RD), .B_RADR(B_RADR), .B_RDATA(B_RDATA),
      .C_WR(C_WR), .C_WADR(C_WADR), .C_WDATA(C_WDATA),
      .BUSY(BUSY), .FINISH(FINISH), .RMAX(RMAX), .RMIN(RMIN)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Operand memories with one-cycle read latency.
   logic [DW-1:0] mem_a [DEPTH];
   logic [DW-1:0] mem_b [DEPTH];

   always @(posedge CLK) begin
      if (A_RD) A_RDATA <= mem_a[A_RADR];
      if (B_RD) B_RDATA <= mem_b[B_RADR];
   end

   // Cycle counter and passive monitors.
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int wr_adr[$];
   int wr_dat[$];
   int wr_cyc[$];
   int rd_adr[$];
   int brd_cnt = 0;

   always @(negedge CLK) begin
      if (C_WR) begin
         wr_adr.push_back(int'(C_WADR));
         wr_dat.push_back(int'($signed(C_WDATA)));
         wr_cyc.push_back(cyc);
      end
      if (A_RD) rd_adr.push_back(int'(A_RADR));
      if (B_RD) brd_cnt++;
   end

   // Reference: one element's result straight from the arithmetic rules.
   function automatic int ref_elem(int a, int b, int op, bit ia, bit ib, int gain, int qs);
      longint x, y, r;
      x = ia ? ((a == VMIN) ? VMAX : -a) : a;
      y = ib ? ((b == VMIN) ? VMAX : -b) : b;
      if (op == 1)      r = x * y * longint'(gain);
      else if (op == 2) r = x * longint'(gain);
      else              r = x + y;
      if (op == 1 || op == 2) begin
         if (qs > 0) r = r + (longint'(1) << (qs - 1));
         r = r >>> qs;
      end
      if (r > VMAX) r = VMAX;
      if (r < VMIN) r = VMIN;
      return int'(r);
   endfunction

   task automatic scramble_inputs();
      OP = 2'($urandom); B_SCALAR = 1'($urandom); INV_A = 1'($urandom); INV_B = 1'($urandom);
      M0VAL = DW'($urandom); A_POS = AW'($urandom); B_POS = AW'($urandom);
      C_POS = AW'($urandom); SIZE = AW'($urandom); GAIN = $urandom; QSHIFT = SW'($urandom);
   endtask

   task automatic run_case(input string nm, input int op, input bit bsc, input bit ia, input bit ib,
                           input int m0, input int apos, input int bpos, input int cpos, input int size,
                           input int gain, input int qs, input int inj_at, input int abort_at);
      int exp_dat[$];
      int emax, emin, a, b, start_cyc, fin_off, fin_cnt, wb, rb, bb, limit, late;
      longint obs_max, obs_min;
      emax = 0; emin = 0; obs_max = 0; obs_min = 0;
      for (int i = 0; i < size; i++) begin
         a = int'($signed(mem_a[(apos + i) % DEPTH]));
         b = bsc ? m0 : int'($signed(mem_b[(bpos + i) % DEPTH]));
         exp_dat.push_back(ref_elem(a, b, op, ia, ib, gain, qs));
         if (i == 0 || exp_dat[i] > emax) emax = exp_dat[i];
         if (i == 0 || exp_dat[i] < emin) emin = exp_dat[i];
      end

      @(negedge CLK);
      wb = wr_adr.size(); rb = rd_adr.size(); bb = brd_cnt; start_cyc = cyc;
      OP = 2'(op); B_SCALAR = bsc; INV_A = ia; INV_B = ib; M0VAL = DW'(m0);
      A_POS = AW'(apos); B_POS = AW'(bpos); C_POS = AW'(cpos); SIZE = AW'(size);
      GAIN = GW'(gain); QSHIFT = SW'(qs);
      START = 1'b1; SOFT_RESET = 1'b0;

      limit = (abort_at > 0) ? 12 : size + 12;
      fin_off = -1; fin_cnt = 0;
      for (int k = 1; k <= limit; k++) begin
         @(negedge CLK);
         START = (k == inj_at);
         SOFT_RESET = (k == abort_at);
         scramble_inputs();
         if (k == 1) check_val({nm, ".busy"}, BUSY, (size != 0));
         if (FINISH) begin
            fin_cnt++;
            if (fin_off < 0) begin
               fin_off = k;
               obs_max = $signed(RMAX);
               obs_min = $signed(RMIN);
            end
         end
         if (abort_at == 0 && fin_off >= 0) break;
      end
      START = 1'b0; SOFT_RESET = 1'b0;

      for (int i = 0; i < size && rb + i < rd_adr.size(); i++)
         check_val({nm, ".radr"}, rd_adr[rb + i], (apos + i) % DEPTH);
      for (int i = 0; i < size && wb + i < wr_adr.size(); i++) begin
         check_val({nm, ".wadr"}, wr_adr[wb + i], (cpos + i) % DEPTH);
         check_val({nm, ".wdat"}, wr_dat[wb + i], exp_dat[i]);
         check_val({nm, ".wcyc"}, wr_cyc[wb + i] - start_cyc, 3 + i);
      end
      check_val({nm, ".nbrd"}, brd_cnt - bb, (bsc || op == 2) ? 0 : rd_adr.size() - rb);

      if (abort_at == 0) begin
         check_val({nm, ".fin_lat"}, fin_off, (size == 0) ? 1 : size + 3);
         check_val({nm, ".nwr"}, wr_adr.size() - wb, size);
         check_val({nm, ".nrd"}, rd_adr.size() - rb, size);
         check_val({nm, ".rmax"}, obs_max, emax);
         check_val({nm, ".rmin"}, obs_min, emin);
      end else begin
         late = 0;
         for (int i = wb; i < wr_cyc.size(); i++)
            if (wr_cyc[i] > start_cyc + abort_at) late++;
         check_val({nm, ".late_wr"}, late, 0);
         check_val({nm, ".abort_fin"}, fin_cnt, 0);
         check_val({nm, ".abort_busy"}, BUSY, 0);
         check_val({nm, ".abort_rmax"}, $signed(RMAX), 0);
         check_val({nm, ".abort_rmin"}, $signed(RMIN), 0);
      end
   endtask

   initial begin
      int sz, op, inj;
      RESET_X = 1'b0; SOFT_RESET = 1'b0; START = 1'b0;
      OP = '0; B_SCALAR = 1'b0; INV_A = 1'b0; INV_B = 1'b0; M0VAL = '0;
      A_POS = '0; B_POS = '0; C_POS = '0; SIZE = '0; GAIN = '0; QSHIFT = '0;
`ifdef NPU_EW_RELU_EN
      RELU = 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = DW'($urandom);
         mem_b[i] = DW'($urandom);
      end

      repeat (3) @(negedge CLK);
      check_val("rst.busy", BUSY, 0);
      check_val("rst.finish", FINISH, 0);
      check_val("rst.strobes", {A_RD, B_RD, C_WR}, 0);
      check_val("rst.rmax", RMAX, 0);
      check_val("rst.rmin", RMIN, 0);
      RESET_X = 1'b1;

      // ADD basic.
      for (int i = 0; i < 4; i++) begin
         mem_a[i] = DW'(i + 1);
         mem_b[100 + i] = DW'(10 * (i + 1));
      end
      run_case("add", 0, 0, 0, 0, 0, 0, 100, 200, 4, 0, 0, 0, 0);

      // Saturating negation then add, and negative saturation.
      mem_a[10] = DW'(-128); mem_b[10] = DW'(5);
      run_case("inv_sat", 0, 0, 1, 0, 0, 10, 10, 300, 1, 0, 0, 0, 0);
      mem_a[11] = DW'(-100); mem_b[11] = DW'(-100);
      run_case("neg_sat", 0, 0, 0, 0, 0, 11, 11, 301, 1, 0, 0, 0, 0);

      // RQT with rounding.
      mem_a[20] = DW'(5); mem_a[21] = DW'(-5); mem_a[22] = DW'(100);
      run_case("rqt", 2, 0, 0, 0, 0, 20, 500, 400, 3, 3, 1, 0, 0);

      // MUL by scalar.
      mem_a[30] = DW'(3); mem_a[31] = DW'(70);
      run_case("mul_sc", 1, 1, 0, 0, -2, 30, 600, 410, 2, 1, 0, 0, 0);

      // Empty run, then a START injected while busy.
      run_case("size0", 0, 0, 0, 0, 0, 40, 40, 420, 0, 0, 0, 0, 0);
      run_case("busy_start", 0, 0, 0, 0, 0, 50, 60, 430, 8, 0, 0, 3, 0);

      // Address wrap on read, aborted by SOFT_RESET.
      run_case("wrap_abort", 0, 0, 0, 0, 0, 1022, 700, 440, 4, 0, 0, 0, 4);

      // Randomized runs.
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = DW'($urandom);
            mem_b[i] = DW'($urandom);
         end
         sz  = $urandom_range(0, 12);
         op  = $urandom_range(0, 3);
         inj = (sz >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, sz) : 0;
         run_case("rand", op, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 255) - 128,
                  $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                  sz, ($urandom_range(0, 1) == 1) ? int'($urandom) : $urandom_range(0, 600) - 300,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(11, 31) : $urandom_range(0, 10), inj, 0);
      end

      repeat (2) @(negedge CLK);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
